// File: rtl/mem_arb_pkg.sv
// Shared state type, grant encodings and read-latency bounds for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 7;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch/data ports, the arbiter and the memory.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    logic [1:0]  grant;
    logic        busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wr, grant, busy
    );

    // Requester/memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_wr, grant, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: data-first by default, round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_d_req,
`ifdef MEM_ARB_RR_EN
    input  logic       i_last_data,
`endif
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = GRANT_NONE;
        if (i_if_req && i_d_req) begin
`ifdef MEM_ARB_RR_EN
            // The side that did not win last time takes the tie.
            o_grant = i_last_data ? GRANT_FETCH : GRANT_DATA;
`else
            o_grant = GRANT_DATA;
`endif
        end else if (i_d_req) begin
            o_grant = GRANT_DATA;
        end else if (i_if_req) begin
            o_grant = GRANT_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise data wins ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT = 3
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                  (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_next;
    logic [1:0]  w_pick;
    logic        r_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        w_start;
    logic        w_read_done;
    logic        w_if_ack;
    logic        w_d_ack;
    logic        w_mem_wr;
`ifdef MEM_ARB_RR_EN
    logic        r_last_data;
`endif

    mem_arb_pick u_pick (
        .i_if_req    (bus.if_req),
        .i_d_req     (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .i_last_data (r_last_data),
`endif
        .o_grant     (w_pick)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_next = r_grant;
        w_start      = 1'b0;
        w_read_done  = 1'b0;
        w_if_ack     = 1'b0;
        w_d_ack      = 1'b0;
        w_mem_wr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant_next = GRANT_NONE;
                if (w_pick != GRANT_NONE) begin
                    w_start      = 1'b1;
                    w_grant_next = w_pick;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_cnt_next = (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
                if (r_we) begin
                    // Writes take a single cycle regardless of read latency.
                    w_mem_wr     = !reset;
                    w_state_next = RESP;
                end else if (r_cnt == 3'd0) begin
                    w_read_done  = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_if_ack     = (r_grant == GRANT_FETCH) && !reset;
                w_d_ack      = (r_grant == GRANT_DATA) && !reset;
                w_grant_next = GRANT_NONE;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_grant <= GRANT_NONE;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_grant <= w_grant_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
        end else begin
            if (w_start) begin
                if (w_pick == GRANT_DATA) begin
                    r_we        <= bus.d_we;
                    r_mem_addr  <= bus.d_addr;
                    r_mem_wdata <= bus.d_wdata;
                end else begin
                    r_we       <= 1'b0;
                    r_mem_addr <= bus.if_addr;
                end
            end
            if (w_read_done) begin
                if (r_grant == GRANT_FETCH) begin
                    r_if_rdata <= bus.mem_rdata;
                end else begin
                    r_d_rdata <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_data <= 1'b0;
        end else if (w_start) begin
            r_last_data <= (w_pick == GRANT_DATA);
        end
    end
`endif

    assign bus.if_ack    = w_if_ack;
    assign bus.d_ack     = w_d_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.grant     = r_grant;
    assign bus.busy      = (r_state != IDLE);

endmodule
